// File: rtl/circular_buffer_fwft_pkg.sv
// Shared defaults and width helpers for the circular-buffer FWFT FIFO.
// Both width helpers are evaluated at elaboration time.
package circular_buffer_fwft_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Occupancy runs 0..depth inclusive, so one extra code is needed.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/circular_buffer_fwft_ctrl.sv
// Pointer, occupancy and handshake control for the circular-buffer FIFO.
// The sub-module holds only control state; the parent holds the storage.
module circ_buf_ctrl
  import circular_buffer_fwft_pkg::*;
#(
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int AF_LEVEL = DEPTH - 1,
  parameter  int AE_LEVEL = 1,
  localparam int CW       = cnt_w(DEPTH),
  localparam int PW       = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          write_en,
  input  logic          read_en,
  output logic          ready,
  output logic          valid,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow,
  output logic          wen,
  output logic [PW-1:0] waddr,
  output logic [PW-1:0] raddr
);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf, unf;
  logic          do_wr, do_rd;

  // Explicit compare-and-wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty        = (cnt == '0);
  assign full         = (cnt == CW'(DEPTH));
  assign valid        = ~empty;
  // A simultaneous pop frees a slot, so a full buffer can still take a word.
  assign ready        = ~full | (read_en & ~empty);
  assign do_rd        = read_en & ~empty;
  assign do_wr        = write_en & ready;
  assign almost_full  = (cnt >= CW'(AF_LEVEL));
  assign almost_empty = (cnt <= CW'(AE_LEVEL));
  assign wen          = do_wr & ~clear;
  assign waddr        = wr_ptr;
  assign raddr        = rd_ptr;
  assign count        = cnt;
  assign overflow     = ovf;
  assign underflow    = unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wrap_inc(wr_ptr);
      if (do_rd) rd_ptr <= wrap_inc(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      ovf <= ovf | (write_en & ~ready);
      unf <= unf | (read_en & empty);
    end
  end

endmodule

// File: rtl/circular_buffer_fwft.sv
// Circular-buffer FIFO with first-word-fall-through head, occupancy flags
// and sticky overflow/underflow. Storage lives here; control in circ_buf_ctrl.
module circular_buffer_fwft
  import circular_buffer_fwft_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int AF_LEVEL = DEPTH - 1,
  parameter  int AE_LEVEL = 1,
  localparam int CW       = cnt_w(DEPTH),
  localparam int PW       = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             write_en,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  input  logic             read_en,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wen;
  logic [PW-1:0]    waddr, raddr;

  circ_buf_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .write_en     (write_en),
    .read_en      (read_en),
    .ready        (ready),
    .valid        (valid),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .wen          (wen),
    .waddr        (waddr),
    .raddr        (raddr)
  );

  // Storage is never reset; stale words are hidden by the valid gate on dout.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= din;
  end

  assign dout = valid ? mem[raddr] : '0;

endmodule

// File: tb/tb_circular_buffer_fwft.sv
// Scoreboard bench for circular_buffer_fwft: DEPTH=4 main instance plus a
// DEPTH=5 instance fed the same stream to exercise non-power-of-two wrap.
`timescale 1ns/1ps
module tb_circular_buffer_fwft;

  logic       clk = 1'b0;
  logic       rst, clear, write_en, read_en;
  logic [7:0] din;

  logic [7:0] dout_a, dout_b;
  logic [2:0] count_a, count_b;
  logic ready_a, valid_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic ready_b, valid_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;

  int checks   = 0;
  int failures = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic mon_b_en;

  always #5 clk = ~clk;

  circular_buffer_fwft #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .write_en(write_en), .din(din),
    .ready(ready_a), .read_en(read_en), .dout(dout_a), .valid(valid_a),
    .full(full_a), .empty(empty_a), .count(count_a), .almost_full(af_a),
    .almost_empty(ae_a), .overflow(ovf_a), .underflow(unf_a));

  circular_buffer_fwft #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .write_en(write_en), .din(din),
    .ready(ready_b), .read_en(read_en), .dout(dout_b), .valid(valid_b),
    .full(full_b), .empty(empty_b), .count(count_b), .almost_full(af_b),
    .almost_empty(ae_b), .overflow(ovf_b), .underflow(unf_b));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a pop happens at the coming edge when valid and read_en are both high.
  always @(negedge clk) begin
    if (!rst && valid_a && read_en) begin
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL pop_a: unexpected word %0d with empty scoreboard", dout_a);
      end else begin
        chk("pop_a", dout_a, q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mon_b_en && valid_b && read_en) begin
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL pop_b: unexpected word %0d with empty scoreboard", dout_b);
      end else begin
        chk("pop_b", dout_b, q_b.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals [4];
    vals[0] = 8'd11; vals[1] = 8'd22; vals[2] = 8'd33; vals[3] = 8'd44;
    rst = 1'b1; clear = 1'b0; write_en = 1'b0; read_en = 1'b0; din = '0; mon_b_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_count", count_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_ready", ready_a, 1);
    chk("rst_dout", dout_a, 0);
    chk("rst_ae", ae_a, 1);
    chk("rst_af", af_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_unf", unf_a, 0);

    // Fill, overflow, drain
    for (int i = 0; i < 4; i++) begin
      write_en = 1'b1; din = vals[i];
      step();
      chk("fill_count", count_a, i + 1);
      chk("fill_af", af_a, (i + 1 >= 3) ? 1 : 0);
    end
    chk("fill_full", full_a, 1);
    chk("fill_ready", ready_a, 0);
    din = 8'd55;
    step();
    write_en = 1'b0;
    chk("ovf_set", ovf_a, 1);
    chk("ovf_count", count_a, 4);
    for (int i = 0; i < 4; i++) begin
      read_en = 1'b1; q_a.push_back(vals[i]);
      step();
    end
    read_en = 1'b0;
    chk("drain_empty", empty_a, 1);
    chk("drain_dout", dout_a, 0);
    chk("drain_valid", valid_a, 0);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_ovf", ovf_a, 0);

    // Full with simultaneous write and read
    for (int i = 0; i < 4; i++) begin
      write_en = 1'b1; din = vals[i];
      step();
    end
    din = 8'd55; read_en = 1'b1; q_a.push_back(8'd11);
    #1 chk("fullboth_ready", ready_a, 1);
    step();
    write_en = 1'b0;
    chk("fullboth_count", count_a, 4);
    q_a.push_back(8'd22); q_a.push_back(8'd33); q_a.push_back(8'd44); q_a.push_back(8'd55);
    repeat (4) step();
    read_en = 1'b0;
    chk("fullboth_empty", empty_a, 1);
    chk("fullboth_ovf", ovf_a, 0);

    // Streaming wrap through DEPTH=4 and DEPTH=5
    clear = 1'b1; step(); clear = 1'b0;
    mon_b_en = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      write_en = (i < 10);
      din = 8'hA0 + 8'(i);
      read_en = (i > 0);
      if (i > 0) begin
        q_a.push_back(8'hA0 + 8'(i - 1));
        q_b.push_back(8'hA0 + 8'(i - 1));
      end
      step();
      chk("wrap_cnt_a", (count_a <= 1) ? 1 : 0, 1);
      chk("wrap_cnt_b", (count_b <= 1) ? 1 : 0, 1);
    end
    write_en = 1'b0; read_en = 1'b0;
    chk("wrap_flags_a", {ovf_a, unf_a}, 0);
    chk("wrap_flags_b", {ovf_b, unf_b}, 0);
    chk("wrap_empty_b", empty_b, 1);
    mon_b_en = 1'b0;

    // Empty-side boundaries
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("unf_set", unf_a, 1);
    chk("unf_count", count_a, 0);
    write_en = 1'b1; din = 8'd66; read_en = 1'b1;
    step();
    write_en = 1'b0; read_en = 1'b0;
    chk("emptyboth_count", count_a, 1);
    chk("emptyboth_dout", dout_a, 66);
    chk("emptyboth_valid", valid_a, 1);

    // Clear overrides a write in the same cycle
    write_en = 1'b1; din = 8'h12; step();
    din = 8'h13; step();
    chk("preclr_count", count_a, 3);
    clear = 1'b1; din = 8'd77;
    step();
    clear = 1'b0; write_en = 1'b0;
    chk("clr_count", count_a, 0);
    chk("clr_empty", empty_a, 1);
    chk("clr_flags", {ovf_a, unf_a}, 0);
    chk("clr_dout", dout_a, 0);
    write_en = 1'b1; din = 8'd88; step(); write_en = 1'b0;
    chk("postclr_count", count_a, 1);
    read_en = 1'b1; q_a.push_back(8'd88); step(); read_en = 1'b0;

    // Asynchronous reset between edges
    write_en = 1'b1; din = 8'h31; step();
    din = 8'h32; step();
    write_en = 1'b0;
    chk("prerst_count", count_a, 2);
    #3 rst = 1'b1;
    #1;
    chk("arst_count", count_a, 0);
    chk("arst_empty", empty_a, 1);
    chk("arst_valid", valid_a, 0);
    chk("arst_dout", dout_a, 0);
    chk("arst_ready", ready_a, 1);
    chk("arst_ae", ae_a, 1);
    #1 rst = 1'b0;
    write_en = 1'b1; din = 8'd99; step(); write_en = 1'b0;
    chk("postrst_count", count_a, 1);
    read_en = 1'b1; q_a.push_back(8'd99); step(); read_en = 1'b0;
    chk("postrst_empty", empty_a, 1);

    chk("drained_a", q_a.size(), 0);
    chk("drained_b", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
